// File: rtl/icache_line.sv
// One instruction-cache line: valid bit, tag and 32-byte data block.
// Combinational lookup; synchronous whole-line fill from the refill path.
module icache_line #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              we,
  input  logic [LINE_W-1:0] data_in,
  output logic              hit,
  output logic [LINE_W-1:0] data_out
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int TAG_W = ADDR_W - OFF_W;

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d = 1'b1;
      tag_d   = w_addr[ADDR_W-1:OFF_W];
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  // Zero on miss so several lines can be OR-combined by the array.
  assign hit      = valid_q && (r_addr[ADDR_W-1:OFF_W] == tag_q);
  assign data_out = hit ? data_q : '0;

endmodule

// File: tb/tb_icache_line.sv
// Bench for icache_line: vector table plus hold and async-reset sequences,
// expected results queued on drive and popped at sample time.
module tb_icache_line;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr;
  logic          we;
  logic [LW-1:0] data_in;
  logic          hit;
  logic [LW-1:0] data_out;

  icache_line #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_addr   (r_addr),
    .w_addr   (w_addr),
    .we       (we),
    .data_in  (data_in),
    .hit      (hit),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] w_addr;
    logic [LW-1:0] data_in;
    logic [AW-1:0] r_addr;
    logic          exp_hit;
    logic [LW-1:0] exp_data;
  } vec_t;

  typedef struct {
    string         name;
    logic          hit;
    logic [LW-1:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  logic [LW-1:0] DB, CF, PT, ZZ;

  function automatic vec_t mk(string n, logic rn, logic w,
                              logic [AW-1:0] wa, logic [LW-1:0] di,
                              logic [AW-1:0] ra, logic eh,
                              logic [LW-1:0] ed);
    vec_t v;
    v.name = n; v.rst_n = rn; v.we = w; v.w_addr = wa;
    v.data_in = di; v.r_addr = ra; v.exp_hit = eh; v.exp_data = ed;
    return v;
  endfunction

  task automatic expect_out(string n, logic eh, logic [LW-1:0] ed);
    exp_t e;
    e.name = n; e.hit = eh; e.data = ed;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb.pop_front();
      if (hit !== e.hit || data_out !== e.data) begin
        n_bad++;
        $display("FAIL %s: got hit=%b data=%h, want hit=%b data=%h",
                 e.name, hit, data_out, e.hit, e.data);
      end
    end
  endtask

  initial begin
    DB = {8{32'hDEADBEEF}};
    CF = {8{32'hCAFEF00D}};
    PT = {4{64'h0123_4567_89AB_CDEF}};
    ZZ = '0;
    n_vec = 0;
    n_bad = 0;

    tbl.push_back(mk("reset_active",  0, 0, 0, 0, 32'h0, 0, ZZ));
    tbl.push_back(mk("reset_release", 1, 0, 0, 0, 32'h0, 0, ZZ));
    tbl.push_back(mk("post_reset",    1, 0, 0, 0, 32'h0, 0, ZZ));
    tbl.push_back(mk("fill_pre_edge", 1, 1, 32'h0, DB, 32'h0, 0, ZZ));
    tbl.push_back(mk("hit_base",      1, 0, 0, 0, 32'h0, 1, DB));
    tbl.push_back(mk("hit_off_1c",    1, 0, 0, 0, 32'h1C, 1, DB));
    tbl.push_back(mk("miss_next",     1, 0, 0, 0, 32'h20, 0, ZZ));
    tbl.push_back(mk("miss_msb",      1, 0, 0, 0, 32'h8000_0000, 0, ZZ));
    tbl.push_back(mk("rdw_old",       1, 1, 32'h1234_5660, CF,
                     32'h0, 1, DB));
    tbl.push_back(mk("old_tag_miss",  1, 0, 0, 0, 32'h0, 0, ZZ));
    tbl.push_back(mk("new_hit_78",    1, 0, 0, 0, 32'h1234_5678, 1, CF));
    tbl.push_back(mk("new_hit_7f",    1, 0, 0, 0, 32'h1234_567F, 1, CF));
    tbl.push_back(mk("new_miss_80",   1, 0, 0, 0, 32'h1234_5680, 0, ZZ));
    tbl.push_back(mk("fill_off_bits", 1, 1, 32'hABCD_EF1F, PT,
                     32'hABCD_EF00, 0, ZZ));
    tbl.push_back(mk("off_fill_hit",  1, 0, 0, 0, 32'hABCD_EF00, 1, PT));
    tbl.push_back(mk("off_fill_lsb",  1, 0, 0, 0, 32'hABCD_EF20, 0, ZZ));
    tbl.push_back(mk("refill_cf",     1, 1, 32'h1234_5660, CF,
                     32'h1234_5660, 0, ZZ));
    tbl.push_back(mk("refill_hit",    1, 0, 0, 0, 32'h1234_5660, 1, CF));

    rst_n   = 1'b1;
    we      = 1'b0;
    r_addr  = '0;
    w_addr  = '0;
    data_in = '0;
    #1;

    // Table: drive after an edge, sample mid-cycle, then take the edge.
    foreach (tbl[i]) begin
      rst_n   = tbl[i].rst_n;
      we      = tbl[i].we;
      w_addr  = tbl[i].w_addr;
      data_in = tbl[i].data_in;
      r_addr  = tbl[i].r_addr;
      expect_out(tbl[i].name, tbl[i].exp_hit, tbl[i].exp_data);
      #2;
      check_out();
      @(posedge clk);
      #1;
    end

    // Hold: junk on the fill side with we low must not disturb the line.
    we     = 1'b0;
    r_addr = 32'h1234_5660;
    for (int k = 0; k < 10; k++) begin
      w_addr  = $urandom;
      data_in = {8{$urandom}};
      expect_out("hold", 1'b1, CF);
      #2;
      check_out();
      @(posedge clk);
      #1;
    end

    // Async reset landing between edges while a fill is requested.
    we      = 1'b1;
    w_addr  = 32'h1234_5660;
    data_in = DB;
    expect_out("pre_async_rst", 1'b1, CF);
    #1;
    check_out();
    #1;
    rst_n = 1'b0;
    expect_out("async_rst_drop", 1'b0, ZZ);
    #1;
    check_out();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      expect_out("rst_blocks_fill", 1'b0, ZZ);
      check_out();
    end
    @(negedge clk);
    rst_n = 1'b1;
    we    = 1'b0;
    @(posedge clk);
    #1;
    expect_out("after_rst_release", 1'b0, ZZ);
    check_out();

    we      = 1'b1;
    w_addr  = 32'h1234_5660;
    data_in = DB;
    @(posedge clk);
    #1;
    we = 1'b0;
    expect_out("fill_after_rst", 1'b1, DB);
    #1;
    check_out();

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
